// File: rtl/csr_pkg.sv
// Shared CSR address map, CSR operation encodings and mstatus bit positions.
package csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS      = 12'h300;
  localparam logic [11:0] CSR_MTVEC        = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
  localparam logic [11:0] CSR_MEPC         = 12'h341;
  localparam logic [11:0] CSR_MCAUSE       = 12'h342;
  localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH      = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH    = 12'hB82;
  localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;

  // Read-modify-write operation requested with a commit strobe
  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // mstatus fields that are implemented; every other bit reads as 0
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // New register value for a write/set/clear; widths up to 64 bits
  function automatic logic [63:0] csr_apply_op(input logic [1:0]  op,
                                               input logic [63:0] old_v,
                                               input logic [63:0] opnd);
    logic [63:0] r;
    case (op)
      CSR_OP_WRITE: r = opnd;
      CSR_OP_SET:   r = old_v | opnd;
      CSR_OP_CLEAR: r = old_v & ~opnd;
      default:      r = old_v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with enable; wraps from all-ones to zero.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [63:0] count
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // Advance by one when enabled; natural 64-bit overflow gives the wrap
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + 64'd1;
    end
  end

  // Counter register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap entry/return, 64-bit cycle/instret counters,
// custom scratch registers, and a one-cycle redirect pulse toward fetch.
//
// Interface timing: CSR_done is a single-cycle commit strobe with no
// back-pressure; the write takes effect at the clock edge where CSR_done is
// high and is visible on csr_out from the following cycle. exception_sig and
// mret_sig are likewise single-cycle strobes; redirect_valid is a one-cycle
// pulse with no ready, and redirect_pc is meaningful only while it is high.
module csr_file
  import csr_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CAUSE_W     = 5,
  parameter int NUM_SCRATCH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exception_sig,
  input  logic [XLEN-1:0]    exception_pc,
  input  logic [CAUSE_W-1:0] exception_cause,
  input  logic               mret_sig,
  input  logic               instr_retire,
  input  logic [11:0]        ID_CSR_Address,
  output logic [XLEN-1:0]    csr_out,
  output logic               csr_illegal,
  input  logic               CSR_done,
  input  logic [1:0]         CSR_op,
  input  logic [11:0]        RS_CSR_Address,
  input  logic [XLEN-1:0]    CSR_Result,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    epc,
  output logic [XLEN-1:0]    cause,
  output logic               mie
);

  localparam int SIDX_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  logic              mie_q, mie_d;
  logic              mpie_q, mpie_d;
  logic [XLEN-1:0]   mtvec_q, mtvec_d;
  logic [XLEN-1:0]   mscratch_q, mscratch_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   scratch_q [NUM_SCRATCH];
  logic [XLEN-1:0]   scratch_d [NUM_SCRATCH];
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

  logic [63:0]       mcycle_w;
  logic [63:0]       minstret_w;
  logic [XLEN-1:0]   mstatus_val;
  logic [XLEN-1:0]   rd_data;
  logic              rd_hit;
  logic              rd_scr_hit;
  logic [SIDX_W-1:0] rd_sidx;
  logic [XLEN-1:0]   wr_old;
  logic [XLEN-1:0]   wr_new;
  logic              wr_scr_hit;
  logic [SIDX_W-1:0] wr_sidx;

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (reset),
    .en    (1'b1),
    .count (mcycle_w)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (reset),
    .en    (instr_retire),
    .count (minstret_w)
  );

  // Architectural view of mstatus: only MIE and MPIE are implemented
  always_comb begin
    mstatus_val                   = '0;
    mstatus_val[MSTATUS_MIE_BIT]  = mie_q;
    mstatus_val[MSTATUS_MPIE_BIT] = mpie_q;
  end

  // Combinational read port; unmapped addresses return 0 and flag illegal
  always_comb begin
    rd_data    = '0;
    rd_hit     = 1'b1;
    rd_scr_hit = (ID_CSR_Address[11:4] == CSR_SCRATCH_BASE[11:4]) &&
                 (int'(ID_CSR_Address[3:0]) < NUM_SCRATCH);
    rd_sidx    = ID_CSR_Address[SIDX_W-1:0];
    case (ID_CSR_Address)
      CSR_MSTATUS:  rd_data = mstatus_val;
      CSR_MTVEC:    rd_data = mtvec_q;
      CSR_MSCRATCH: rd_data = mscratch_q;
      CSR_MEPC:     rd_data = mepc_q;
      CSR_MCAUSE:   rd_data = mcause_q;
      CSR_MCYCLE:   rd_data = XLEN'(mcycle_w);
      CSR_MINSTRET: rd_data = XLEN'(minstret_w);
      CSR_MCYCLEH: begin
        if (XLEN == 32) rd_data = XLEN'(mcycle_w >> 32);
        else            rd_hit  = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (XLEN == 32) rd_data = XLEN'(minstret_w >> 32);
        else            rd_hit  = 1'b0;
      end
      default: begin
        if (rd_scr_hit) rd_data = scratch_q[rd_sidx];
        else            rd_hit  = 1'b0;
      end
    endcase
  end

  assign csr_out     = rd_data;
  assign csr_illegal = ~rd_hit;

  // Old value of the write target and the value the requested op produces
  always_comb begin
    wr_old     = '0;
    wr_scr_hit = (RS_CSR_Address[11:4] == CSR_SCRATCH_BASE[11:4]) &&
                 (int'(RS_CSR_Address[3:0]) < NUM_SCRATCH);
    wr_sidx    = RS_CSR_Address[SIDX_W-1:0];
    case (RS_CSR_Address)
      CSR_MSTATUS:  wr_old = mstatus_val;
      CSR_MTVEC:    wr_old = mtvec_q;
      CSR_MSCRATCH: wr_old = mscratch_q;
      CSR_MEPC:     wr_old = mepc_q;
      CSR_MCAUSE:   wr_old = mcause_q;
      default: begin
        if (wr_scr_hit) wr_old = scratch_q[wr_sidx];
      end
    endcase
    wr_new = XLEN'(csr_apply_op(CSR_op, 64'(wr_old), 64'(CSR_Result)));
  end

  // Next state: trap entry beats trap return beats CSR commit; losers drop
  always_comb begin
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    scratch_d        = scratch_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (exception_sig) begin
      mepc_d           = exception_pc;
      mepc_d[1:0]      = 2'b00;
      mcause_d         = XLEN'(exception_cause);
      mpie_d           = mie_q;
      mie_d            = 1'b0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mtvec_q;
    end else if (mret_sig) begin
      mie_d            = mpie_q;
      mpie_d           = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_q;
    end else if (CSR_done && (CSR_op != CSR_OP_NONE)) begin
      // Counters, unmapped addresses and read-only bits fall through untouched
      case (RS_CSR_Address)
        CSR_MSTATUS: begin
          mie_d  = wr_new[MSTATUS_MIE_BIT];
          mpie_d = wr_new[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC: begin
          mtvec_d      = wr_new;
          mtvec_d[1:0] = 2'b00;
        end
        CSR_MSCRATCH: mscratch_d = wr_new;
        CSR_MEPC: begin
          mepc_d      = wr_new;
          mepc_d[1:0] = 2'b00;
        end
        CSR_MCAUSE: mcause_d = wr_new;
        default: begin
          if (wr_scr_hit) scratch_d[wr_sidx] = wr_new;
        end
      endcase
    end
  end

  // CSR state and redirect registers; reset also cancels a pending redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mtvec_q          <= '0;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= '0;
      end
    end else begin
      mie_q            <= mie_d;
      mpie_q           <= mpie_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= scratch_d[i];
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign epc            = mepc_q;
  assign cause          = mcause_q;
  assign mie            = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios with literal expectations, then
// randomized traffic, all outputs compared every cycle against a
// behavioural model of the CSR file.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exception_sig = 1'b0;
  logic [31:0] exception_pc = 32'h0;
  logic [4:0]  exception_cause = 5'h0;
  logic        mret_sig = 1'b0;
  logic        instr_retire = 1'b0;
  logic [11:0] ID_CSR_Address = 12'h300;
  logic        CSR_done = 1'b0;
  logic [1:0]  CSR_op = 2'b00;
  logic [11:0] RS_CSR_Address = 12'h000;
  logic [31:0] CSR_Result = 32'h0;
  logic [31:0] csr_out;
  logic        csr_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [31:0] cause;
  logic        mie;

  csr_file #(.XLEN(32), .CAUSE_W(5), .NUM_SCRATCH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .exception_sig   (exception_sig),
    .exception_pc    (exception_pc),
    .exception_cause (exception_cause),
    .mret_sig        (mret_sig),
    .instr_retire    (instr_retire),
    .ID_CSR_Address  (ID_CSR_Address),
    .csr_out         (csr_out),
    .csr_illegal     (csr_illegal),
    .CSR_done        (CSR_done),
    .CSR_op          (CSR_op),
    .RS_CSR_Address  (RS_CSR_Address),
    .CSR_Result      (CSR_Result),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .epc             (epc),
    .cause           (cause),
    .mie             (mie)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit              m_mie, m_mpie, m_rv;
  logic [31:0]     m_mtvec, m_mscratch, m_mepc, m_mcause, m_rpc;
  logic [31:0]     m_scr [2];
  longint unsigned m_cycle, m_instret;
  int              preload_seq = 0;
  int              preload_seen = 0;
  longint unsigned preload_val = 0;

  function automatic void model_read(input logic [11:0] a, output logic [31:0] d, output bit ill);
    d = 32'h0;
    ill = 1'b0;
    case (a)
      12'h300: d = 32'(m_mie) * 8 + 32'(m_mpie) * 128;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'hB00: d = 32'(m_cycle % 64'h1_0000_0000);
      12'hB02: d = 32'(m_instret % 64'h1_0000_0000);
      12'hB80: d = 32'(m_cycle / 64'h1_0000_0000);
      12'hB82: d = 32'(m_instret / 64'h1_0000_0000);
      12'h7C0: d = m_scr[0];
      12'h7C1: d = m_scr[1];
      default: ill = 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin : model_upd
    logic [31:0] old_v, new_v;
    bit          ill;
    if (!reset) begin
      m_mie = 0; m_mpie = 0; m_rv = 0;
      m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_rpc = 0;
      m_scr[0] = 0; m_scr[1] = 0;
      m_cycle = 0; m_instret = 0;
    end else begin
      if (preload_seq != preload_seen) begin
        preload_seen = preload_seq;
        m_cycle = preload_val + 1;
      end else begin
        m_cycle = m_cycle + 1;
      end
      if (instr_retire) m_instret = m_instret + 1;
      m_rv = 0;
      if (exception_sig) begin
        m_rv     = 1;
        m_rpc    = m_mtvec;
        m_mepc   = exception_pc - (exception_pc % 4);
        m_mcause = 32'(exception_cause);
        m_mpie   = m_mie;
        m_mie    = 0;
      end else if (mret_sig) begin
        m_rv   = 1;
        m_rpc  = m_mepc;
        m_mie  = m_mpie;
        m_mpie = 1;
      end else if (CSR_done && CSR_op != 2'b00) begin
        model_read(RS_CSR_Address, old_v, ill);
        if (CSR_op == 2'b01)      new_v = CSR_Result;
        else if (CSR_op == 2'b10) new_v = old_v | CSR_Result;
        else                      new_v = old_v & ~CSR_Result;
        case (RS_CSR_Address)
          12'h300: begin m_mie = new_v[3]; m_mpie = new_v[7]; end
          12'h305: m_mtvec = new_v - (new_v % 4);
          12'h340: m_mscratch = new_v;
          12'h341: m_mepc = new_v - (new_v % 4);
          12'h342: m_mcause = new_v;
          12'h7C0: m_scr[0] = new_v;
          12'h7C1: m_scr[1] = new_v;
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver helpers ----------------
  logic [11:0] addr_tab [15] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0,
                                 12'h7C1, 12'h7C2, 12'h7FF, 12'h000, 12'hF14};

  // Advance one clock; inputs set afterwards apply to the following edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    ID_CSR_Address = a;
    #1;
    chk(name, csr_out, exp);
  endtask

  task automatic clear_inputs();
    exception_sig = 0; mret_sig = 0; CSR_done = 0; CSR_op = 2'b00; instr_retire = 0;
  endtask

  // ---------------- main ----------------
  initial begin
    // per-cycle comparison of every output against the model
    fork
      forever begin : cmp_loop
        logic [31:0] e_d;
        bit          e_ill;
        @(negedge clk);
        model_read(ID_CSR_Address, e_d, e_ill);
        chk("csr_out", csr_out, e_d);
        chk("csr_illegal", 32'(csr_illegal), 32'(e_ill));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        chk("epc", epc, m_mepc);
        chk("cause", cause, m_mcause);
        chk("mie", 32'(mie), 32'(m_mie));
      end
    join_none

    // reset and counter start
    #1 reset = 1'b0;
    repeat (3) cyc();
    chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    rd_chk("rst_mstatus", 12'h300, 32'h0);
    rd_chk("rst_mcycle", 12'hB00, 32'h0);
    reset = 1'b1;
    repeat (10) cyc();
    rd_chk("mcycle_10", 12'hB00, 32'd10);
    rd_chk("unmapped_out", 12'h7FF, 32'h0);
    chk("unmapped_illegal", 32'(csr_illegal), 32'h1);
    instr_retire = 1;
    repeat (3) cyc();
    instr_retire = 0;
    rd_chk("minstret_3", 12'hB02, 32'd3);

    // mtvec write with low bits masked, then a trap
    CSR_done = 1; CSR_op = 2'b01; RS_CSR_Address = 12'h305; CSR_Result = 32'h0000_0103;
    cyc();
    clear_inputs();
    rd_chk("mtvec_masked", 12'h305, 32'h0000_0100);
    exception_sig = 1; exception_pc = 32'h80; exception_cause = 5'd2;
    cyc();
    clear_inputs();
    chk("trap_redirect_valid", 32'(redirect_valid), 32'h1);
    chk("trap_redirect_pc", redirect_pc, 32'h100);
    chk("trap_epc", epc, 32'h80);
    chk("trap_cause", cause, 32'h2);
    cyc();
    chk("trap_pulse_end", 32'(redirect_valid), 32'h0);

    // MIE set, trap, mret
    CSR_done = 1; CSR_op = 2'b10; RS_CSR_Address = 12'h300; CSR_Result = 32'h8;
    cyc();
    clear_inputs();
    rd_chk("mstatus_mie_set", 12'h300, 32'h8);
    exception_sig = 1; exception_pc = 32'h80; exception_cause = 5'd3;
    cyc();
    clear_inputs();
    rd_chk("mstatus_after_trap", 12'h300, 32'h80);
    mret_sig = 1;
    cyc();
    clear_inputs();
    rd_chk("mstatus_after_mret", 12'h300, 32'h88);
    chk("mret_redirect_valid", 32'(redirect_valid), 32'h1);
    chk("mret_redirect_pc", redirect_pc, 32'h80);

    // exception + CSR write + mret in the same cycle
    exception_sig = 1; exception_pc = 32'h40; exception_cause = 5'd7;
    mret_sig = 1;
    CSR_done = 1; CSR_op = 2'b01; RS_CSR_Address = 12'h341; CSR_Result = 32'h200;
    cyc();
    clear_inputs();
    chk("prio_epc", epc, 32'h40);
    chk("prio_redirect_pc", redirect_pc, 32'h100);
    rd_chk("prio_mstatus", 12'h300, 32'h80);
    cyc();
    chk("prio_single_pulse", 32'(redirect_valid), 32'h0);
    rd_chk("prio_mepc", 12'h341, 32'h40);

    // mcycle wrap through a preloaded value
    ID_CSR_Address = 12'h300;
    preload_val = 64'hFFFF_FFFF_FFFF_FFFE;
    preload_seq++;
    force dut.u_mcycle.count_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.u_mcycle.count_q;
    cyc();
    rd_chk("mcycleh_before_wrap", 12'hB80, 32'hFFFF_FFFF);
    repeat (2) cyc();
    rd_chk("mcycle_wrapped", 12'hB00, 32'h1);
    rd_chk("mcycleh_wrapped", 12'hB80, 32'h0);

    // reset during the redirect cycle
    exception_sig = 1; exception_pc = 32'h84; exception_cause = 5'd1;
    cyc();
    clear_inputs();
    chk("pre_reset_redirect", 32'(redirect_valid), 32'h1);
    reset = 1'b0;
    #1;
    chk("reset_kills_redirect", 32'(redirect_valid), 32'h0);
    chk("reset_epc", epc, 32'h0);
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    rd_chk("mcycle_after_reset", 12'hB00, 32'h1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      exception_sig   = ($urandom_range(0, 19) == 0);
      exception_pc    = $urandom();
      exception_cause = 5'($urandom_range(0, 31));
      mret_sig        = ($urandom_range(0, 15) == 0);
      instr_retire    = 1'($urandom_range(0, 1));
      CSR_done        = ($urandom_range(0, 2) == 0);
      CSR_op          = 2'($urandom_range(0, 3));
      RS_CSR_Address  = addr_tab[$urandom_range(0, 14)];
      CSR_Result      = $urandom();
      ID_CSR_Address  = addr_tab[$urandom_range(0, 14)];
      reset           = ($urandom_range(0, 499) != 0);
      cyc();
    end
    clear_inputs();
    reset = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data width of every CSR and PC port.
REQ-002 SHALL have parameter CAUSE_W, default 5, the exception cause code width.
REQ-003 SHALL have parameter NUM_SCRATCH, default 2, the number of custom scratch CSRs at 0x7C0..0x7C0+NUM_SCRATCH-1 (range 1..16).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: exception_sig in 1 trap request; exception_pc in XLEN faulting PC; exception_cause in CAUSE_W cause code.
REQ-007 SHALL have ports: mret_sig in 1 trap return; instr_retire in 1 one instruction retired this cycle.
REQ-008 SHALL have ports: ID_CSR_Address in 12 read address; csr_out out XLEN read data; csr_illegal out 1 read address unmapped.
REQ-009 SHALL have ports: CSR_done in 1 write commit strobe; CSR_op in 2 (01 write, 10 set, 11 clear, 00 none); RS_CSR_Address in 12; CSR_Result in XLEN operand.
REQ-010 SHALL have ports: redirect_valid out 1; redirect_pc out XLEN; epc out XLEN (mepc mirror); cause out XLEN (mcause mirror); mie out 1 (mstatus.MIE).

Function
REQ-011 Map: mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0); mtvec 0x305; mscratch 0x340; mepc 0x341; mcause 0x342; mcycle 0xB00; minstret 0xB02; mcycleh 0xB80 and minstreth 0xB82 when XLEN=32.
REQ-012 Read SHALL be combinational from current state; same-cycle commit is not forwarded; write visible on csr_out the cycle after CSR_done.
REQ-013 Unmapped read address SHALL drive csr_out=0, csr_illegal=1; otherwise csr_illegal=0.
REQ-014 On CSR_done: new = op01 ? CSR_Result : op10 ? old|CSR_Result : op11 ? old&~CSR_Result : old; op00 no change.
REQ-015 Writes to counters, unmapped addresses, or read-only bits SHALL be ignored silently; mepc bits[1:0] and mtvec bits[1:0] SHALL be stored as 0.
REQ-016 mcycle SHALL be 64 bits, increment every cycle out of reset, wrap 2^64-1 -> 0.
REQ-017 minstret SHALL be 64 bits, increment on instr_retire, wrap likewise.
REQ-018 Exception (trap entry), in one clock: mepc<=exception_pc, mcause<={0,cause zero-extended}, MPIE<=MIE, MIE<=0.
REQ-019 mret: MIE<=MPIE, MPIE<=1.
REQ-020 redirect_valid SHALL pulse high exactly one cycle after the trap or mret cycle; redirect_pc = mtvec (trap) or mepc (mret) sampled at that event cycle.
REQ-021 Priority same cycle: exception > mret > CSR_done; a lower-priority event in the same cycle is dropped entirely, not deferred.
REQ-022 Exception and mret both set redirect; exception target wins.
REQ-023 Back-to-back exceptions on consecutive cycles SHALL each update mepc/mcause and each produce one redirect pulse.
REQ-024 epc, cause, mie SHALL be continuous mirrors of stored state.

Reset
REQ-025 On reset low, asynchronously: all CSRs, counters, redirect_valid, redirect_pc = 0; MIE=0, MPIE=0.
REQ-026 Reset mid-trap SHALL cancel any pending redirect pulse; counters resume from 0 the first edge after release.

Structure
REQ-027 CSR address constants, CSR_op encodings and mstatus bit positions SHALL live in shared package csr_pkg.
REQ-028 One sub-module, csr_counter64 (64-bit wrapping counter, enable, reset), SHALL be instantiated twice (mcycle, minstret).
REQ-029 Scratch CSRs SHALL be an array sized by NUM_SCRATCH; no other storage arrays.

Verification
REQ-030 Reset, hold 10 cycles, read 0xB00 -> csr_out=10 (+/-1 per sampling edge); 0x7FF -> csr_illegal=1, csr_out=0.
REQ-031 Write 0x305=0x00000103 -> mtvec reads 0x00000100; exception pc=0x80, cause=2 -> next cycle redirect_valid=1, redirect_pc=0x100, epc=0x80, cause=2.
REQ-032 Set MIE (op10 0x300 operand 0x8), exception, mret -> after exception mstatus=0x80; after mret mstatus=0x88, redirect_pc=0x80.
REQ-033 Same cycle exception pc=0x40 + CSR_done write mepc=0x200 + mret -> mepc=0x40, one redirect to mtvec, write dropped.
REQ-034 Preload mcycle via force to 0xFFFFFFFF_FFFFFFFE, run 3 cycles -> reads 1; mcycleh=0 after wrap.
REQ-035 Assert reset low during redirect cycle -> redirect_valid=0 immediately; mepc=0.
